// File: rtl/ffe_tap_line.sv
// rtl/ffe_tap_line.sv - FFE sample delay line that sweeps its taps to the MAC after each accepted sample
module ffe_tap_line #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int ADDR_SIZE  = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         ffe_clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [CNT_W-1:0]             num_taps,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         tap_valid,
    input  logic                         tap_ready,
    output logic signed [DATA_WIDTH-1:0] tap_data,
    output logic [ADDR_SIZE-1:0]         tap_idx,
    output logic                         tap_last,
    output logic [CNT_W-1:0]             fill_cnt,
    output logic                         primed
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t                         r_state;
    logic signed [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [CNT_W-1:0]               r_fill;
    logic [CNT_W-1:0]               r_n_eff;
    logic [ADDR_SIZE-1:0]           r_idx;

    logic                           w_accept;
    logic                           w_in_fill;
    logic [CNT_W-1:0]               w_n_clamp;

    assign w_n_clamp = (num_taps == '0 || num_taps > DEPTH_C) ? DEPTH_C : num_taps;
    assign in_ready  = (r_state == IDLE) && !flush;
    assign w_accept  = in_valid && in_ready;

    // Tap outputs decode straight from registered state, so they hold while tap_ready is low.
    assign tap_valid = (r_state == SWEEP);
    assign w_in_fill = CNT_W'(r_idx) < r_fill;
    assign tap_idx   = tap_valid ? r_idx : '0;
    assign tap_data  = (tap_valid && w_in_fill) ? r_mem[r_idx] : '0;
    assign tap_last  = tap_valid && (CNT_W'(r_idx) == r_n_eff - CNT_W'(1));
    assign fill_cnt  = r_fill;
    assign primed    = (r_fill == DEPTH_C);

    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_fill  <= '0;
            r_n_eff <= DEPTH_C;
            r_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_state <= IDLE;
            r_fill  <= '0;
            r_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mem[0] <= in_data;
                        for (int i = 1; i < DEPTH; i++) begin
                            r_mem[i] <= r_mem[i-1];
                        end
                        if (r_fill != DEPTH_C) begin
                            r_fill <= r_fill + CNT_W'(1);
                        end
                        r_n_eff <= w_n_clamp;
                        r_idx   <= '0;
                        r_state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (tap_ready) begin
                        if (tap_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + ADDR_SIZE'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffe_tap_line.sv
// tb/tb_ffe_tap_line.sv - directed and randomized checks of ffe_tap_line against a queue-based model
module tb_ffe_tap_line;

    localparam int DW        = 12;
    localparam int DEPTH     = 8;
    localparam int ADDR_SIZE = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                  ffe_clk   = 1'b0;
    logic                  rst       = 1'b1;
    logic                  flush     = 1'b0;
    logic [CNT_W-1:0]      num_taps  = '0;
    logic                  in_valid  = 1'b0;
    logic signed [DW-1:0]  in_data   = '0;
    logic                  tap_ready = 1'b0;
    logic                  in_ready;
    logic                  tap_valid;
    logic signed [DW-1:0]  tap_data;
    logic [ADDR_SIZE-1:0]  tap_idx;
    logic                  tap_last;
    logic [CNT_W-1:0]      fill_cnt;
    logic                  primed;

    int checks = 0;
    int errors = 0;

    // newest sample at index 0, at most DEPTH entries
    logic signed [DW-1:0] m_q [$];

    ffe_tap_line #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .ffe_clk  (ffe_clk),
        .rst      (rst),
        .flush    (flush),
        .num_taps (num_taps),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tap_valid(tap_valid),
        .tap_ready(tap_ready),
        .tap_data (tap_data),
        .tap_idx  (tap_idx),
        .tap_last (tap_last),
        .fill_cnt (fill_cnt),
        .primed   (primed)
    );

    always #5 ffe_clk = ~ffe_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic int n_eff_of(int nt);
        return (nt == 0 || nt > DEPTH) ? DEPTH : nt;
    endfunction

    function automatic logic signed [DW-1:0] m_tap(int i);
        if (i < m_q.size()) return m_q[i];
        return '0;
    endfunction

    task automatic m_push(logic signed [DW-1:0] d);
        m_q.push_front(d);
        if (m_q.size() > DEPTH) void'(m_q.pop_back());
    endtask

    task automatic step();
        @(posedge ffe_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge ffe_clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (tap_valid !== 1'b0) begin errors++; $display("FAIL reset_tap_valid: got %b expected 0", tap_valid); end
        checks++; if (tap_idx !== '0 || tap_last !== 1'b0) begin errors++; $display("FAIL reset_idx_last: got idx %0d last %b expected 0 0", tap_idx, tap_last); end
        checks++; if (tap_data !== '0) begin errors++; $display("FAIL reset_tap_data: got %0d expected 0", tap_data); end
        checks++; if (fill_cnt !== '0 || primed !== 1'b0) begin errors++; $display("FAIL reset_fill: got fill %0d primed %b expected 0 0", fill_cnt, primed); end
        m_q.delete();
        step();
    endtask

    task automatic test_basic();
        logic signed [DW-1:0] vals [3];
        vals[0] = 12'sd5; vals[1] = -12'sd3; vals[2] = 12'sd7;
        num_taps  = CNT_W'(4);
        tap_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1;
            in_data  = vals[s];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
            checks++; if (fill_cnt !== CNT_W'(s)) begin errors++; $display("FAIL basic_fill: got %0d expected %0d", fill_cnt, s); end
            step();
            m_push(vals[s]);
            in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++; if (tap_valid !== 1'b1 || tap_idx !== ADDR_SIZE'(i) || tap_last !== (i == 3)) begin errors++; $display("FAIL basic_tap_ctl: got valid %b idx %0d last %b expected 1 %0d %b", tap_valid, tap_idx, tap_last, i, i == 3); end
                checks++; if (tap_data !== m_tap(i)) begin errors++; $display("FAIL basic_tap_data: idx %0d got %0d expected %0d", i, tap_data, m_tap(i)); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got in_ready %b expected 0", in_ready); end
                step();
            end
        end
        #1;
        checks++; if (fill_cnt !== CNT_W'(3) || tap_valid !== 1'b0) begin errors++; $display("FAIL basic_end: got fill %0d valid %b expected 3 0", fill_cnt, tap_valid); end
        step();
    endtask

    task automatic test_fill();
        int last_acc = -100;
        int nacc = 0;
        int exp_idx;
        bit done = 1'b0;
        bit acc;
        logic signed [DW-1:0] oldest = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_q.delete();
        num_taps  = '0;
        tap_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'sd1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            #1;
            acc = 1'b0;
            if (nacc == 10 && cyc - last_acc == 9) begin
                done = 1'b1;
            end else if (in_ready) begin
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 9) begin errors++; $display("FAIL fill_interval: got %0d cycles expected 9", cyc - last_acc); end
                end
                checks++; if (fill_cnt !== CNT_W'((nacc < DEPTH) ? nacc : DEPTH) || primed !== (nacc >= DEPTH)) begin errors++; $display("FAIL fill_count: got fill %0d primed %b after %0d accepts", fill_cnt, primed, nacc); end
                acc = 1'b1;
                last_acc = cyc;
                nacc++;
                m_push(in_data);
            end else begin
                exp_idx = cyc - last_acc - 1;
                checks++; if (tap_valid !== 1'b1 || tap_idx !== ADDR_SIZE'(exp_idx) || tap_last !== (exp_idx == DEPTH - 1) || tap_data !== m_tap(exp_idx)) begin errors++; $display("FAIL fill_tap: got valid %b idx %0d last %b data %0d expected 1 %0d %b %0d", tap_valid, tap_idx, tap_last, tap_data, exp_idx, exp_idx == DEPTH - 1, m_tap(exp_idx)); end
                if (exp_idx == DEPTH - 1) oldest = tap_data;
            end
            if (!done) begin
                step();
                if (acc) begin
                    in_data = in_data + 12'sd1;
                    if (nacc == 10) in_valid = 1'b0;
                end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL fill_timeout: got %0d accepts expected 10", nacc); end
        checks++; if (fill_cnt !== CNT_W'(DEPTH) || primed !== 1'b1) begin errors++; $display("FAIL fill_final: got fill %0d primed %b expected %0d 1", fill_cnt, primed, DEPTH); end
        checks++; if (oldest !== 12'sd3) begin errors++; $display("FAIL fill_oldest: got %0d expected 3", oldest); end
        step();
    endtask

    task automatic test_backpressure();
        int exp_idx = 0;
        int stall = 0;
        int cycles = 0;
        bit done = 1'b0;
        num_taps  = '0;
        tap_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        while (!done && cycles < 40) begin
            tap_ready = !(exp_idx == 2 && stall < 3);
            #1;
            checks++; if (tap_valid !== 1'b1 || tap_idx !== ADDR_SIZE'(exp_idx) || tap_last !== (exp_idx == DEPTH - 1)) begin errors++; $display("FAIL bp_tap_ctl: got valid %b idx %0d last %b expected 1 %0d %b", tap_valid, tap_idx, tap_last, exp_idx, exp_idx == DEPTH - 1); end
            checks++; if (tap_data !== m_tap(exp_idx)) begin errors++; $display("FAIL bp_tap_data: idx %0d got %0d expected %0d", exp_idx, tap_data, m_tap(exp_idx)); end
            step();
            cycles++;
            if (tap_ready) begin
                if (exp_idx == DEPTH - 1) done = 1'b1;
                else exp_idx++;
            end else begin
                stall++;
            end
        end
        tap_ready = 1'b1;
        #1;
        checks++; if (!done || cycles != DEPTH + 3 || tap_valid !== 1'b0) begin errors++; $display("FAIL bp_length: got %0d cycles valid %b expected %0d 0", cycles, tap_valid, DEPTH + 3); end
        step();
    endtask

    task automatic test_flush();
        num_taps  = CNT_W'(4);
        tap_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        #1;
        checks++; if (tap_idx !== '0 || tap_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got idx %0d valid %b expected 0 1", tap_idx, tap_valid); end
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'sd99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        checks++; if (tap_idx !== ADDR_SIZE'(1) || tap_last !== 1'b0) begin errors++; $display("FAIL flush_at_idx1: got idx %0d last %b expected 1 0", tap_idx, tap_last); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        m_q.delete();
        #1;
        checks++; if (tap_valid !== 1'b0 || tap_last !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got valid %b last %b ready %b expected 0 0 1", tap_valid, tap_last, in_ready); end
        checks++; if (fill_cnt !== '0) begin errors++; $display("FAIL flush_fill: got %0d expected 0", fill_cnt); end
        step();
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tap_idx !== ADDR_SIZE'(i) || tap_data !== m_tap(i) || fill_cnt !== CNT_W'(1)) begin errors++; $display("FAIL flush_resweep: idx %0d got data %0d fill %0d expected %0d 1", i, tap_data, fill_cnt, m_tap(i)); end
            step();
        end
    endtask

    task automatic test_async_reset();
        num_taps  = '0;
        tap_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tap_valid !== 1'b0 || tap_idx !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_outputs: got valid %b idx %0d ready %b expected 0 0 1", tap_valid, tap_idx, in_ready); end
        checks++; if (fill_cnt !== '0 || primed !== 1'b0) begin errors++; $display("FAIL arst_fill: got %0d primed %b expected 0 0", fill_cnt, primed); end
        #1;
        rst = 1'b0;
        m_q.delete();
        step();
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if (tap_data !== m_tap(i)) begin errors++; $display("FAIL arst_taps: idx %0d got %0d expected %0d", i, tap_data, m_tap(i)); end
            step();
        end
    endtask

    task automatic test_single_tap();
        num_taps  = CNT_W'(1);
        tap_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        #1;
        checks++; if (tap_valid !== 1'b1 || tap_idx !== '0 || tap_last !== 1'b1 || tap_data !== m_tap(0)) begin errors++; $display("FAIL single_tap: got valid %b idx %0d last %b data %0d expected 1 0 1 %0d", tap_valid, tap_idx, tap_last, tap_data, m_tap(0)); end
        num_taps = CNT_W'(3);
        step();
        #1;
        checks++; if (tap_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_done: got valid %b ready %b expected 0 1", tap_valid, in_ready); end
        step();
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        #1;
        step();
        m_push(in_data);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (tap_idx !== ADDR_SIZE'(i) || tap_last !== (i == 2) || tap_data !== m_tap(i)) begin errors++; $display("FAIL three_tap: got idx %0d last %b data %0d expected %0d %b %0d", tap_idx, tap_last, tap_data, i, i == 2, m_tap(i)); end
            step();
        end
        #1;
        checks++; if (tap_valid !== 1'b0) begin errors++; $display("FAIL three_done: got valid %b expected 0", tap_valid); end
        step();
    endtask

    task automatic test_random();
        bit m_sweep = 1'b0;
        int m_idx = 0;
        int m_n = DEPTH;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            tap_ready = ($urandom_range(0, 3) != 0);
            num_taps  = CNT_W'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 40) == 0);
            #1;
            checks++; if (in_ready !== (!m_sweep && !flush)) begin errors++; $display("FAIL rand_in_ready: cyc %0d got %b expected %b", cyc, in_ready, !m_sweep && !flush); end
            checks++; if (tap_valid !== m_sweep) begin errors++; $display("FAIL rand_tap_valid: cyc %0d got %b expected %b", cyc, tap_valid, m_sweep); end
            if (m_sweep) begin
                checks++; if (tap_idx !== ADDR_SIZE'(m_idx) || tap_last !== (m_idx == m_n - 1) || tap_data !== m_tap(m_idx)) begin errors++; $display("FAIL rand_tap: cyc %0d got idx %0d last %b data %0d expected %0d %b %0d", cyc, tap_idx, tap_last, tap_data, m_idx, m_idx == m_n - 1, m_tap(m_idx)); end
            end
            checks++; if (fill_cnt !== CNT_W'(m_q.size()) || primed !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_fill: cyc %0d got %0d primed %b expected %0d", cyc, fill_cnt, primed, m_q.size()); end
            step();
            if (flush) begin
                m_q.delete();
                m_sweep = 1'b0;
            end else if (!m_sweep) begin
                if (in_valid) begin
                    m_push(in_data);
                    m_n = n_eff_of(int'(num_taps));
                    m_idx = 0;
                    m_sweep = 1'b1;
                end
            end else if (tap_ready) begin
                if (m_idx == m_n - 1) m_sweep = 1'b0;
                else m_idx++;
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_single_tap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
